pin_mux_ctrl: RTL and testbench
===============================

Name: pin_mux_ctrl

Overview:
Parametrised pin multiplexer for the MKR/NINA/PEX GPIO banks. Each pin selects between software PIO (function 0) and up to FUNCS-1 peripheral sources (PWM, SPI, UART bypass, and so on). Select changes are glitch-free: an enforced tristate guard interval separates the old and new driver. The block also synchronises pin inputs and raises an edge interrupt. It sits between the Avalon-MM system bus and the top-level tristate buffers.

Parameters:
PINS, 32, number of pins handled; legal range 1..32.
FUNCS, 4, number of selectable functions including PIO; legal range 2..16.
GUARD, 4, tristate cycles inserted on a select change; legal range 1..255.
SYNC_STAGES, 2, input synchroniser depth; legal range 2..4.

Ports:
iCLK  in  1  system clock (all logic on this clock).
iRESET  in  1  synchronous reset, active high.
iAVL_ADDRESS  in  4  word address.
iAVL_READ  in  1  read strobe.
iAVL_WRITE  in  1  write strobe.
iAVL_WRITE_DATA  in  32  write data.
oAVL_READ_DATA  out  32  read data, valid exactly 1 cycle after iAVL_READ.
iFUNC_OUT  in  FUNCS*PINS  per-function output data; slice k = [k*PINS +: PINS]; slice 0 ignored.
iFUNC_OE  in  FUNCS*PINS  per-function output enable; same slicing; slice 0 ignored.
iPIN_I  in  PINS  raw pad input, asynchronous.
oPIN_O  out  PINS  pad output data.
oPIN_OE  out  PINS  pad output enable; top level drives 1'bz when 0.
oPIN_IN  out  PINS  synchronised pad input, for peripherals.
oIRQ  out  1  level interrupt.

Behaviour:
Interface: one clock, iCLK; reset is synchronous and active-high on iRESET. No wait states.

Register map (word address; bits at or above PINS read 0 and writes to them are ignored):
- 0 PIO_OUT: RW.
- 1 PIO_DIR: RW; 1 = output.
- 2 PIO_IN: RO; returns oPIN_IN.
- 3 IRQ_MASK: RW.
- 4 IRQ_STATUS: RO with write-1-to-clear.
- 8..11 MSEL: 8 pins per word, 4-bit field per pin; pin p is at word 8+p/8, bits [4*(p%8)+3 : 4*(p%8)].
- Any other address reads 0; writes to it are ignored.

MSEL writes:
- A field value >= FUNCS is ignored and that field keeps its old requested value.
- Reads return the requested select, not the active select.

Per-pin select state machine:
- States: ACTIVE and GUARD; reset state is ACTIVE with active select = 0 and requested select = 0.
- ACTIVE: a write whose requested value differs from the active select loads the guard counter with GUARD and goes to GUARD.
- ACTIVE: a write of the same value does nothing.
- GUARD: oPIN_OE[p] is forced to 0 and oPIN_O[p] to 0. The counter decrements each cycle. At count 1 the state returns to ACTIVE with active select = requested select.
- GUARD: a new differing write reloads the counter to GUARD and updates the requested select.
- GUARD: a write equal to the current active select also restarts the guard. No early exit.

Output path (registered, 1-cycle latency from any source):
- Active select 0: oPIN_O = PIO_OUT[p], oPIN_OE = PIO_DIR[p].
- Active select k: oPIN_O = iFUNC_OUT[k*PINS+p], oPIN_OE = iFUNC_OE[k*PINS+p].

Input path:
- iPIN_I passes through SYNC_STAGES flops to give oPIN_IN.
- A rising edge is detected between oPIN_IN and a one-cycle-delayed copy; it sets IRQ_STATUS[p] on the cycle after the edge appears on oPIN_IN.
- A write-1-to-clear and a new edge on the same pin in the same cycle: set wins.

Interrupt:
- oIRQ is registered: oIRQ = |(IRQ_STATUS & IRQ_MASK), with 1-cycle lag.
- Edges on masked-off pins still set IRQ_STATUS.

Reset values:
- All registers = 0.
- oPIN_O = 0, oPIN_OE = 0 (all pins tristate), oIRQ = 0, oAVL_READ_DATA = 0.
- Synchroniser flops and edge history = 0.
- Guard counters = 0 and all pins ACTIVE.
- Reset asserted mid-guard aborts the guard; the pin returns to select 0, tristate.

Simultaneous read and write to the same address: the read returns the pre-write value.

Test Plan:
- Reset, then read all addresses -> all 0; oPIN_OE = 0; oIRQ = 0.
- Write PIO_DIR = 0x0000_00FF, PIO_OUT = 0x0000_00A5 -> one cycle later oPIN_OE = 0xFF, oPIN_O = 0xA5; reading address 0 returns 0xA5.
- With pin 3 driving PIO=1, write MSEL word 8 = 0x0000_2000 (pin 3 -> function 2), with iFUNC_OE slice 2 = all 1s and iFUNC_OUT pin 3 = 0 -> oPIN_OE[3] = 0 for exactly 4 cycles, then oPIN_OE[3] = 1 and oPIN_O[3] = 0. Other pins remain undisturbed throughout.
- During that guard, at cycle 2, write pin 3 -> function 1 -> guard restarts to 4 more cycles, then function 1 drives. Writing field value 15 with FUNCS=4 -> ignored; read back shows 1.
- Set IRQ_MASK = 0x1; drive iPIN_I[0] 0->1 -> IRQ_STATUS[0] = 1 after 3 cycles (SYNC_STAGES=2), oIRQ = 1 one cycle later. Write 0x1 to address 4 in the same cycle as a new edge -> bit stays 1.
- Assert iRESET while pin 5 is in GUARD toward function 3 -> next cycle pin 5 is at select 0 with oPIN_OE[5] = 0; MSEL reads 0.

Source files
------------

// File: rtl/pin_mux_ctrl.sv
// GPIO pin multiplexer: per-pin function select with a tristate guard interval on
// every select change, PIO registers, pad input synchroniser and rising-edge IRQ.
module pin_mux_ctrl #(
  parameter int unsigned PINS        = 32,
  parameter int unsigned FUNCS       = 4,
  parameter int unsigned GUARD       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  iCLK,
  input  logic                  iRESET,
  input  logic [3:0]            iAVL_ADDRESS,
  input  logic                  iAVL_READ,
  input  logic                  iAVL_WRITE,
  input  logic [31:0]           iAVL_WRITE_DATA,
  output logic [31:0]           oAVL_READ_DATA,
  input  logic [FUNCS*PINS-1:0] iFUNC_OUT,
  input  logic [FUNCS*PINS-1:0] iFUNC_OE,
  input  logic [PINS-1:0]       iPIN_I,
  output logic [PINS-1:0]       oPIN_O,
  output logic [PINS-1:0]       oPIN_OE,
  output logic [PINS-1:0]       oPIN_IN,
  output logic                  oIRQ
);

  localparam int unsigned SEL_W      = 4;
  localparam int unsigned CNT_W      = 8;
  localparam int unsigned MSEL_WORDS = 4;

  typedef enum logic {ST_ACTIVE = 1'b0, ST_GUARD = 1'b1} sel_state_t;

  logic [PINS-1:0]  r_pio_out;
  logic [PINS-1:0]  r_pio_dir;
  logic [PINS-1:0]  r_irq_mask;
  logic [PINS-1:0]  r_irq_status;
  logic [PINS-1:0]  r_in_d;
  logic [PINS-1:0]  r_sync [SYNC_STAGES];
  logic [31:0]      r_rd_data;
  logic             r_irq;
  logic [PINS-1:0]  r_pin_o;
  logic [PINS-1:0]  r_pin_oe;
  sel_state_t       r_state [PINS];
  logic [SEL_W-1:0] r_act [PINS];
  logic [SEL_W-1:0] r_req [PINS];
  logic [CNT_W-1:0] r_cnt [PINS];

  logic [PINS-1:0]  w_wdata;
  logic [PINS-1:0]  w_pin_in;
  logic [PINS-1:0]  w_rise;
  logic [PINS-1:0]  w_clr;
  logic [PINS-1:0]  w_func_o;
  logic [PINS-1:0]  w_func_oe;
  logic [PINS-1:0]  w_sel_wr;
  logic [SEL_W-1:0] w_fld [PINS];
  logic [31:0]      w_msel_word [MSEL_WORDS];
  logic [31:0]      w_rd_data;
  logic             w_unused_slice0;

  assign w_wdata         = iAVL_WRITE_DATA[PINS-1:0];
  assign w_pin_in        = r_sync[SYNC_STAGES-1];
  assign w_rise          = w_pin_in & ~r_in_d;
  assign w_clr           = (iAVL_WRITE && (iAVL_ADDRESS == 4'd4)) ? w_wdata : '0;
  // Function slice 0 is the PIO slot; its bus inputs carry nothing.
  assign w_unused_slice0 = ^{iFUNC_OUT[PINS-1:0], iFUNC_OE[PINS-1:0]};

  // Per-pin select-write decode and peripheral source selection.
  always_comb begin
    for (int p = 0; p < PINS; p++) begin
      w_fld[p]     = iAVL_WRITE_DATA[4*(p%8) +: SEL_W];
      w_sel_wr[p]  = iAVL_WRITE && (iAVL_ADDRESS == 4'(8 + p/8)) &&
                     ({1'b0, w_fld[p]} < 5'(FUNCS));
      w_func_o[p]  = 1'b0;
      w_func_oe[p] = 1'b0;
      for (int k = 1; k < FUNCS; k++) begin
        if (r_act[p] == SEL_W'(k)) begin
          w_func_o[p]  = iFUNC_OUT[k*PINS + p];
          w_func_oe[p] = iFUNC_OE[k*PINS + p];
        end
      end
    end
  end

  // MSEL readback packs the requested (not active) selects.
  always_comb begin
    for (int w = 0; w < MSEL_WORDS; w++) begin
      w_msel_word[w] = '0;
    end
    for (int p = 0; p < PINS; p++) begin
      w_msel_word[p/8][4*(p%8) +: SEL_W] = r_req[p];
    end
  end

  always_comb begin
    w_rd_data = '0;
    case (iAVL_ADDRESS)
      4'd0:                w_rd_data = 32'(r_pio_out);
      4'd1:                w_rd_data = 32'(r_pio_dir);
      4'd2:                w_rd_data = 32'(w_pin_in);
      4'd3:                w_rd_data = 32'(r_irq_mask);
      4'd4:                w_rd_data = 32'(r_irq_status);
      4'd8, 4'd9,
      4'd10, 4'd11:        w_rd_data = w_msel_word[iAVL_ADDRESS[1:0]];
      default:             w_rd_data = '0;
    endcase
  end

  // Bus registers, input synchroniser, edge capture and interrupt.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      r_pio_out    <= '0;
      r_pio_dir    <= '0;
      r_irq_mask   <= '0;
      r_irq_status <= '0;
      r_in_d       <= '0;
      r_rd_data    <= '0;
      r_irq        <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      if (iAVL_WRITE && (iAVL_ADDRESS == 4'd0)) r_pio_out  <= w_wdata;
      if (iAVL_WRITE && (iAVL_ADDRESS == 4'd1)) r_pio_dir  <= w_wdata;
      if (iAVL_WRITE && (iAVL_ADDRESS == 4'd3)) r_irq_mask <= w_wdata;
      r_irq_status <= (r_irq_status & ~w_clr) | w_rise;
      r_sync[0]    <= iPIN_I;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_in_d    <= w_pin_in;
      r_irq     <= |(r_irq_status & r_irq_mask);
      r_rd_data <= iAVL_READ ? w_rd_data : '0;
    end
  end

  // Per-pin select FSM; any accepted write while guarding restarts the guard.
  always_ff @(posedge iCLK) begin
    for (int p = 0; p < PINS; p++) begin
      if (iRESET) begin
        r_state[p]  <= ST_ACTIVE;
        r_act[p]    <= '0;
        r_req[p]    <= '0;
        r_cnt[p]    <= '0;
        r_pin_o[p]  <= 1'b0;
        r_pin_oe[p] <= 1'b0;
      end else begin
        r_pin_o[p]  <= 1'b0;
        r_pin_oe[p] <= 1'b0;
        if (r_state[p] == ST_ACTIVE) begin
          if (r_act[p] == '0) begin
            r_pin_o[p]  <= r_pio_out[p];
            r_pin_oe[p] <= r_pio_dir[p];
          end else begin
            r_pin_o[p]  <= w_func_o[p];
            r_pin_oe[p] <= w_func_oe[p];
          end
        end
        case (r_state[p])
          ST_ACTIVE: begin
            if (w_sel_wr[p] && (w_fld[p] != r_act[p])) begin
              r_req[p]   <= w_fld[p];
              r_cnt[p]   <= CNT_W'(GUARD);
              r_state[p] <= ST_GUARD;
            end
          end
          ST_GUARD: begin
            if (w_sel_wr[p]) begin
              r_req[p] <= w_fld[p];
              r_cnt[p] <= CNT_W'(GUARD);
            end else if (r_cnt[p] == CNT_W'(1)) begin
              r_state[p] <= ST_ACTIVE;
              r_act[p]   <= r_req[p];
              r_cnt[p]   <= '0;
            end else begin
              r_cnt[p] <= r_cnt[p] - CNT_W'(1);
            end
          end
        endcase
      end
    end
  end

  assign oPIN_O         = r_pin_o;
  assign oPIN_OE        = r_pin_oe;
  assign oPIN_IN        = w_pin_in;
  assign oIRQ           = r_irq;
  assign oAVL_READ_DATA = r_rd_data;

endmodule

// File: tb/tb_pin_mux_ctrl.sv
// Bench for pin_mux_ctrl: register table, guard/IRQ/reset sequences, then random
// traffic against a timestamp-based reference model.
module tb_pin_mux_ctrl;

  localparam int P = 32;
  localparam int F = 4;
  localparam int G = 4;
  localparam int S = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     addr;
  logic           rd;
  logic           wr;
  logic [31:0]    wdata;
  logic [31:0]    rdata;
  logic [F*P-1:0] fout;
  logic [F*P-1:0] foe;
  logic [P-1:0]   pin_i;
  logic [P-1:0]   pin_o;
  logic [P-1:0]   pin_oe;
  logic [P-1:0]   pin_in;
  logic           irq;

  pin_mux_ctrl #(.PINS(P), .FUNCS(F), .GUARD(G), .SYNC_STAGES(S)) dut (
    .iCLK(clk), .iRESET(rst), .iAVL_ADDRESS(addr), .iAVL_READ(rd), .iAVL_WRITE(wr),
    .iAVL_WRITE_DATA(wdata), .oAVL_READ_DATA(rdata), .iFUNC_OUT(fout), .iFUNC_OE(foe),
    .iPIN_I(pin_i), .oPIN_O(pin_o), .oPIN_OE(pin_oe), .oPIN_IN(pin_in), .oIRQ(irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: a pin guards up to and including edge m_gu[p].
  logic [31:0] m_pio_out = '0, m_dir = '0, m_mask = '0, m_status = '0;
  logic [31:0] m_hist [8];
  int          m_act [P];
  int          m_req [P];
  int          m_gu  [P];
  int          edge_n = 0;
  logic [31:0] e_o = '0, e_oe = '0, e_in = '0, e_rd = '0;
  logic        e_irq = 1'b0;
  logic        rd_chk = 1'b0;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        chk_pin;
    logic [31:0] exp_o;
    logic [31:0] exp_oe;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic w, logic r, logic [3:0] a, logic [31:0] d,
                              logic cr, logic [31:0] er, logic cp,
                              logic [31:0] eo, logic [31:0] eoe);
    vec_t v;
    v.wr = w; v.rd = r; v.addr = a; v.wdata = d; v.chk_rd = cr; v.exp_rd = er;
    v.chk_pin = cp; v.exp_o = eo; v.exp_oe = eoe;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h (t=%0t)", nm, got, want, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] a);
    logic [31:0] v;
    int ai;
    v  = '0;
    ai = int'(a);
    case (ai)
      0: v = m_pio_out;
      1: v = m_dir;
      2: v = m_hist[S-1];
      3: v = m_mask;
      4: v = m_status;
      8, 9, 10, 11: for (int j = 0; j < 8; j++) v = v | (32'(m_req[(ai-8)*8 + j]) << (4*j));
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic model_edge();
    logic [31:0] rise, clr;
    bit guard_pre, wr_pin;
    int f, base;
    edge_n++;
    if (rst) begin
      m_pio_out = '0; m_dir = '0; m_mask = '0; m_status = '0;
      for (int p = 0; p < P; p++) begin m_act[p] = 0; m_req[p] = 0; m_gu[p] = 0; end
      for (int i = 0; i < 8; i++) m_hist[i] = '0;
      e_o = '0; e_oe = '0; e_in = '0; e_irq = 1'b0; e_rd = '0; rd_chk = rd;
      return;
    end
    for (int p = 0; p < P; p++) begin
      guard_pre = (edge_n <= m_gu[p]);
      if (guard_pre) begin
        e_o[p] = 1'b0; e_oe[p] = 1'b0;
      end else if (m_act[p] == 0) begin
        e_o[p] = m_pio_out[p]; e_oe[p] = m_dir[p];
      end else begin
        e_o[p] = fout[m_act[p]*P + p]; e_oe[p] = foe[m_act[p]*P + p];
      end
    end
    e_irq  = |(m_status & m_mask);
    rd_chk = rd;
    e_rd   = rd ? model_read(addr) : '0;
    rise     = m_hist[S-1] & ~m_hist[S];
    clr      = (wr && addr == 4'd4) ? wdata : '0;
    m_status = (m_status & ~clr) | rise;
    if (wr && addr == 4'd0) m_pio_out = wdata;
    if (wr && addr == 4'd1) m_dir     = wdata;
    if (wr && addr == 4'd3) m_mask    = wdata;
    base = int'(addr) - 8;
    for (int p = 0; p < P; p++) begin
      guard_pre = (edge_n <= m_gu[p]);
      f         = int'((wdata >> (4*(p%8))) & 32'hF);
      wr_pin    = wr && (p/8 == base) && (f < F);
      if (wr_pin && (guard_pre || f != m_act[p])) begin
        m_req[p] = f;
        m_gu[p]  = edge_n + G;
      end else if (!wr_pin && guard_pre && edge_n == m_gu[p]) begin
        m_act[p] = m_req[p];
      end
    end
    for (int i = 7; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = pin_i;
    e_in = m_hist[S-1];
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("pin_o", pin_o, e_o);
    chk("pin_oe", pin_oe, e_oe);
    chk("pin_in", pin_in, e_in);
    chk("irq", 32'(irq), 32'(e_irq));
    if (rd_chk) chk("rd_data", rdata, e_rd);
  endtask

  task automatic bus(input logic w, input logic r, input logic [3:0] a, input logic [31:0] d);
    wr = w; rd = r; addr = a; wdata = d;
    tick();
    wr = 1'b0; rd = 1'b0;
  endtask

  initial begin
    int zeros;
    for (int i = 0; i < 8; i++) m_hist[i] = '0;
    for (int p = 0; p < P; p++) begin m_act[p] = 0; m_req[p] = 0; m_gu[p] = 0; end
    rst = 1'b1; addr = '0; rd = 1'b0; wr = 1'b0; wdata = '0;
    fout = '0; foe = '0; pin_i = '0;

    vecs.push_back(mk(1, 0, 4'd1,  32'h0000_00FF, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 4'd0,  32'h0000_00A5, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'd0,  32'h0,         1, 32'hA5, 1, 32'hA5, 32'hFF));
    vecs.push_back(mk(0, 1, 4'd1,  32'h0,         1, 32'hFF, 0, 0, 0));
    vecs.push_back(mk(1, 1, 4'd0,  32'h0000_005A, 1, 32'hA5, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'd0,  32'h0,         1, 32'h5A, 0, 0, 0));
    vecs.push_back(mk(1, 0, 4'd0,  32'h0000_00A5, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 4'd3,  32'h0000_0001, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'd3,  32'h0,         1, 32'h1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 4'd8,  32'h0000_00F0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'd8,  32'h0,         1, 32'h0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 4'd12, 32'hFFFF_FFFF, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'd12, 32'h0,         1, 32'h0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 4'd4,  32'hFFFF_FFFF, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'd4,  32'h0,         1, 32'h0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'd2,  32'h0,         1, 32'h0, 1, 32'hA5, 32'hFF));

    tick();
    tick();
    chk("rst_oe", pin_oe, 32'h0);
    chk("rst_o", pin_o, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    rst = 1'b0;
    for (int a = 0; a < 16; a++) begin
      bus(1'b0, 1'b1, 4'(a), '0);
      chk("rst_read", rdata, 32'h0);
    end

    foreach (vecs[i]) begin
      bus(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata);
      if (vecs[i].chk_rd) chk("tbl_rd", rdata, vecs[i].exp_rd);
      if (vecs[i].chk_pin) begin
        chk("tbl_pin_o", pin_o, vecs[i].exp_o);
        chk("tbl_pin_oe", pin_oe, vecs[i].exp_oe);
      end
    end

    // Pin 3 from PIO (driving 1) to function 2: four guard cycles.
    foe[2*P +: P] = '1;
    bus(1'b1, 1'b0, 4'd0, 32'h0000_00AD);
    tick();
    chk("g_pio3", 32'({pin_oe[3], pin_o[3]}), 32'h3);
    bus(1'b1, 1'b0, 4'd8, 32'h0000_2000);
    chk("g_edge_oe3", 32'(pin_oe[3]), 32'h1);
    zeros = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (!pin_oe[3]) zeros++;
      chk("g_other_oe", 32'(pin_oe[7:0]) & ~32'h8, 32'hF7);
      chk("g_other_o", 32'(pin_o[7:0]) & ~32'h8, 32'hA5);
    end
    chk("g_zero_cycles", 32'(zeros), 32'd4);
    chk("g_after_f2", 32'({pin_oe[3], pin_o[3]}), 32'h2);

    // Guard restarted by a second write two cycles in.
    foe[1*P + 3] = 1'b1;
    fout[1*P + 3] = 1'b1;
    bus(1'b1, 1'b0, 4'd8, 32'h0000_0000);
    tick();
    chk("r_mid_oe3", 32'(pin_oe[3]), 32'h0);
    bus(1'b1, 1'b0, 4'd8, 32'h0000_1000);
    chk("r_wr_oe3", 32'(pin_oe[3]), 32'h0);
    zeros = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (!pin_oe[3]) zeros++;
    end
    chk("r_zero_cycles", 32'(zeros), 32'd4);
    chk("r_after_f1", 32'({pin_oe[3], pin_o[3]}), 32'h3);
    bus(1'b1, 1'b0, 4'd8, 32'h0000_F000);
    tick();
    chk("r_bad_fld_oe3", 32'(pin_oe[3]), 32'h1);
    bus(1'b0, 1'b1, 4'd8, '0);
    chk("r_msel_read", rdata, 32'h0000_1000);

    // Rising edge on pin 0, then W1C colliding with a new edge.
    pin_i[0] = 1'b1;
    tick();
    tick();
    bus(1'b0, 1'b1, 4'd4, '0);
    chk("i_stat_early", rdata, 32'h0);
    chk("i_irq_early", 32'(irq), 32'h0);
    bus(1'b0, 1'b1, 4'd4, '0);
    chk("i_stat_set", rdata, 32'h1);
    chk("i_irq_set", 32'(irq), 32'h1);
    pin_i[0] = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    bus(1'b1, 1'b0, 4'd4, 32'h1);
    tick();
    chk("i_irq_clr", 32'(irq), 32'h0);
    pin_i[0] = 1'b1;
    tick();
    tick();
    bus(1'b1, 1'b0, 4'd4, 32'h1);
    bus(1'b0, 1'b1, 4'd4, '0);
    chk("i_set_wins", rdata, 32'h1);

    // Reset while pin 5 is guarding toward function 3.
    bus(1'b1, 1'b0, 4'd8, 32'h0030_1000);
    tick();
    rst = 1'b1;
    tick();
    chk("x_oe", pin_oe, 32'h0);
    chk("x_o", pin_o, 32'h0);
    rst = 1'b0;
    bus(1'b0, 1'b1, 4'd8, '0);
    chk("x_msel", rdata, 32'h0);
    bus(1'b1, 1'b0, 4'd1, 32'h20);
    bus(1'b1, 1'b0, 4'd0, 32'h20);
    tick();
    chk("x_pin5_oe", pin_oe, 32'h20);
    chk("x_pin5_o", pin_o, 32'h20);

    // Random traffic checked by the model inside tick().
    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(0, 299) == 0);
      wr    = ($urandom_range(0, 9) < 4);
      rd    = ($urandom_range(0, 2) == 0);
      addr  = 4'($urandom_range(0, 15));
      wdata = $urandom;
      fout  = {$urandom, $urandom, $urandom, $urandom};
      foe   = {$urandom, $urandom, $urandom, $urandom};
      pin_i = $urandom;
      tick();
    end
    rst = 1'b0; wr = 1'b0; rd = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
